// File: rtl/char_fetch_seq.sv
// rtl/char_fetch_seq.sv - per-scanline character fetch sequencer feeding the pixel-buffer writer
module char_fetch_seq #(
    parameter int COLS = 100
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [3:0]  pixel_row,
    output logic        busy,
    output logic        line_done,
    output logic        chrowbuf_rd_n,
    output logic [7:0]  chrowbuf_rd_addr,
    input  logic [15:0] chrowbuf_rd_data,
    output logic        palette_rd_n,
    output logic [7:0]  palette_rd_addr,
    input  logic [15:0] palette_rd_data,
    output logic        fontmem_rd_n,
    output logic [11:0] fontmem_rd_addr,
    input  logic [7:0]  fontmem_rd_data,
    output logic        char_valid,
    input  logic        char_ready,
    output logic [7:0]  char_pattern,
    output logic [15:0] char_fg,
    output logic [15:0] char_bg
);

    localparam logic [7:0] LAST_COL = 8'(COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_CHAR,
        RD_FG,
        RD_BG,
        CAPTURE,
        WAIT_OUT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [7:0]  col;
    logic [3:0]  row_q;
    logic [3:0]  bg_idx;
    logic [15:0] fg_q;
    logic [7:0]  pat_q;
    logic [15:0] bg_q;
    logic        load;
    logic        last_col;
    logic        slot_free;
    logic        accept_start;

    assign last_col     = (col == LAST_COL);
    assign slot_free    = !char_valid || char_ready;
    assign accept_start = (state == IDLE) && start;

    // State register
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, memory read strobes and slot-load decision
    always_comb begin
        next_state       = state;
        chrowbuf_rd_n    = 1'b1;
        chrowbuf_rd_addr = 8'd0;
        palette_rd_n     = 1'b1;
        palette_rd_addr  = 8'd0;
        fontmem_rd_n     = 1'b1;
        fontmem_rd_addr  = 12'd0;
        load             = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RD_CHAR;
                end
            end
            RD_CHAR: begin
                chrowbuf_rd_n    = 1'b0;
                chrowbuf_rd_addr = col;
                next_state       = RD_FG;
            end
            RD_FG: begin
                palette_rd_n    = 1'b0;
                palette_rd_addr = {4'b0000, chrowbuf_rd_data[11:8]};
                fontmem_rd_n    = 1'b0;
                fontmem_rd_addr = {chrowbuf_rd_data[7:0], row_q};
                next_state      = RD_BG;
            end
            RD_BG: begin
                palette_rd_n    = 1'b0;
                palette_rd_addr = {4'b0000, bg_idx};
                next_state      = CAPTURE;
            end
            CAPTURE: begin
                if (slot_free) begin
                    load       = 1'b1;
                    next_state = last_col ? IDLE : RD_CHAR;
                end else begin
                    next_state = WAIT_OUT;
                end
            end
            WAIT_OUT: begin
                if (char_ready) begin
                    load       = 1'b1;
                    next_state = last_col ? IDLE : RD_CHAR;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Captured fetch data, column counter, output slot and status flags
    always_ff @(posedge clk) begin
        if (!nrst) begin
            col          <= 8'd0;
            row_q        <= 4'd0;
            bg_idx       <= 4'd0;
            fg_q         <= 16'd0;
            pat_q        <= 8'd0;
            bg_q         <= 16'd0;
            busy         <= 1'b0;
            line_done    <= 1'b0;
            char_valid   <= 1'b0;
            char_pattern <= 8'd0;
            char_fg      <= 16'd0;
            char_bg      <= 16'd0;
        end else begin
            line_done <= 1'b0;
            if (accept_start) begin
                col   <= 8'd0;
                row_q <= pixel_row;
                busy  <= 1'b1;
            end else if (line_done) begin
                busy <= 1'b0;
            end
            if (state == RD_FG) begin
                bg_idx <= chrowbuf_rd_data[15:12];
            end
            if (state == RD_BG) begin
                fg_q  <= palette_rd_data;
                pat_q <= fontmem_rd_data;
            end
            if (state == CAPTURE) begin
                bg_q <= palette_rd_data;
            end
            if (load) begin
                char_pattern <= pat_q;
                char_fg      <= fg_q;
                char_bg      <= (state == CAPTURE) ? palette_rd_data : bg_q;
                char_valid   <= 1'b1;
                if (last_col) begin
                    line_done <= 1'b1;
                end else begin
                    col <= col + 8'd1;
                end
            end else if (char_ready) begin
                char_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_char_fetch_seq.sv
// tb/tb_char_fetch_seq.sv - directed self-checking bench for char_fetch_seq
module tb_char_fetch_seq;

    logic clk = 1'b0;
    logic nrst;
    always #12.5 clk = ~clk;

    logic [15:0] rowbuf  [256];
    logic [15:0] palette [256];
    logic [7:0]  font    [4096];

    // Instance with a full 100-column line
    logic        start, ready, busy, line_done, valid;
    logic [3:0]  prow;
    logic        rb_n, pal_n, fm_n;
    logic [7:0]  rb_addr, pal_addr, pat;
    logic [11:0] fm_addr;
    logic [15:0] rb_data = 16'd0, pal_data = 16'd0, fg, bg;
    logic [7:0]  fm_data = 8'd0;

    // Instance with a single-column line
    logic        start1, ready1, busy1, line_done1, valid1;
    logic [3:0]  prow1;
    logic        rb_n1, pal_n1, fm_n1;
    logic [7:0]  rb_addr1, pal_addr1, pat1;
    logic [11:0] fm_addr1;
    logic [15:0] rb_data1 = 16'd0, pal_data1 = 16'd0, fg1, bg1;
    logic [7:0]  fm_data1 = 8'd0;

    int checks = 0;
    int errors = 0;
    int k;

    char_fetch_seq #(.COLS(100)) dut (
        .clk(clk), .nrst(nrst), .start(start), .pixel_row(prow),
        .busy(busy), .line_done(line_done),
        .chrowbuf_rd_n(rb_n), .chrowbuf_rd_addr(rb_addr), .chrowbuf_rd_data(rb_data),
        .palette_rd_n(pal_n), .palette_rd_addr(pal_addr), .palette_rd_data(pal_data),
        .fontmem_rd_n(fm_n), .fontmem_rd_addr(fm_addr), .fontmem_rd_data(fm_data),
        .char_valid(valid), .char_ready(ready),
        .char_pattern(pat), .char_fg(fg), .char_bg(bg)
    );

    char_fetch_seq #(.COLS(1)) u_one (
        .clk(clk), .nrst(nrst), .start(start1), .pixel_row(prow1),
        .busy(busy1), .line_done(line_done1),
        .chrowbuf_rd_n(rb_n1), .chrowbuf_rd_addr(rb_addr1), .chrowbuf_rd_data(rb_data1),
        .palette_rd_n(pal_n1), .palette_rd_addr(pal_addr1), .palette_rd_data(pal_data1),
        .fontmem_rd_n(fm_n1), .fontmem_rd_addr(fm_addr1), .fontmem_rd_data(fm_data1),
        .char_valid(valid1), .char_ready(ready1),
        .char_pattern(pat1), .char_fg(fg1), .char_bg(bg1)
    );

    // Registered-read memory models, one read port set per instance
    always @(posedge clk) begin
        if (!rb_n)   rb_data   <= rowbuf[rb_addr];
        if (!pal_n)  pal_data  <= palette[pal_addr];
        if (!fm_n)   fm_data   <= font[fm_addr];
        if (!rb_n1)  rb_data1  <= rowbuf[rb_addr1];
        if (!pal_n1) pal_data1 <= palette[pal_addr1];
        if (!fm_n1)  fm_data1  <= font[fm_addr1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rowbuf[i]  = 16'(i);
            palette[i] = 16'd0;
        end
        for (int a = 0; a < 4096; a++) begin
            font[a] = 8'(a >> 4) ^ 8'((a & 15) << 4);
        end
        palette[0] = 16'h0ABC;
        palette[1] = 16'h0CC0;
        palette[2] = 16'h0004;
        rowbuf[0]  = 16'h2141;
        font[12'h413] = 8'h8A;

        nrst = 1'b0; start = 1'b0; ready = 1'b0; prow = 4'd0;
        start1 = 1'b0; ready1 = 1'b0; prow1 = 4'd0;
        step(); step(); step();

        // Reset state of both instances
        check("rst_busy", busy, 0);
        check("rst_line_done", line_done, 0);
        check("rst_valid", valid, 0);
        check("rst_rd_n", {rb_n, pal_n, fm_n}, 3'b111);
        check("rst_addrs", {rb_addr, pal_addr, fm_addr}, 0);
        check("rst_slot", {pat, fg, bg}, 0);
        check("rst1_flags", {busy1, line_done1, valid1}, 0);
        check("rst1_rd_n", {rb_n1, pal_n1, fm_n1}, 3'b111);
        check("rst1_slot", {pat1, fg1, bg1}, 0);
        nrst = 1'b1;
        step();

        // Single-character line
        start1 = 1'b1; prow1 = 4'd3; ready1 = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            start1 = 1'b0;
            if (c == 1) check("one_busy_c1", busy1, 1);
            if (c == 2) check("one_font_addr", fm_addr1, 12'h413);
            if (c == 4) check("one_valid_c4", valid1, 0);
            if (c == 5) begin
                check("one_valid_c5", valid1, 1);
                check("one_pattern", pat1, 8'h8A);
                check("one_fg", fg1, 16'h0CC0);
                check("one_bg", bg1, 16'h0004);
                check("one_line_done_c5", line_done1, 1);
            end
            if (c == 6) check("one_idle_c6", {busy1, line_done1}, 0);
        end
        rowbuf[0] = 16'h0000;

        // Full line, ready held high, stray start at cycle 10 with row 7
        start = 1'b1; prow = 4'd2; ready = 1'b1;
        k = 0;
        for (int c = 1; c <= 403; c++) begin
            step();
            start = (c == 10);
            if (c == 10) prow = 4'd7;
            if (!fm_n) check("full_font_row", fm_addr[3:0], 4'd2);
            if (valid) begin
                check("full_spacing", c, 5 + 4 * k);
                check("full_pattern", pat, 8'(k) ^ 8'h20);
                check("full_colours", {fg, bg}, {16'h0ABC, 16'h0ABC});
                check("full_line_done", line_done, (k == 99));
                k++;
            end
            if (c == 400) check("full_busy_c400", busy, 1);
            if (c == 402) check("full_busy_c402", {busy, line_done}, 0);
        end
        check("full_count", k, 100);
        start = 1'b0;

        // Back-pressure: ready low for 20 cycles after the first valid
        prow = 4'd2; ready = 1'b0; start = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            step();
            start = 1'b0;
            ready = (c >= 25);
            if (c >= 5 && c <= 25) check("bp_frozen", {valid, pat, fg}, {1'b1, 8'h20, 16'h0ABC});
            if (c >= 9 && c <= 25) check("bp_rd_n", {rb_n, pal_n, fm_n}, 3'b111);
            if (c == 26) check("bp_col1", {valid, pat}, {1'b1, 8'h21});
            if (c == 27) check("bp_c27_empty", valid, 0);
            if (c == 30) check("bp_col2", {valid, pat}, {1'b1, 8'h22});
        end

        // Abort the line mid-flight
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        check("abort_valid", valid, 0);

        // Reset during RD_BG
        start = 1'b1; prow = 4'd2;
        for (int c = 1; c <= 4; c++) begin
            step();
            start = 1'b0;
            if (c == 3) begin
                check("rbg_rd_n", {rb_n, pal_n, fm_n}, 3'b101);
                nrst = 1'b0;
            end
            if (c == 4) begin
                check("rbg_after_rst", {valid, busy, rb_n, pal_n, fm_n}, 5'b00111);
                nrst = 1'b1;
            end
        end
        step();
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            start = 1'b0;
            if (c == 1) check("fresh_col0", {rb_n, rb_addr}, 9'h000);
            if (c == 5) check("fresh_first", {valid, pat}, {1'b1, 8'h20});
        end
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        step();

        // Two consecutive lines: row 15 then row 0
        start = 1'b1; prow = 4'd15;
        for (int c = 1; c <= 402; c++) begin
            step();
            start = 1'b0;
            if (c == 2)   check("l15_font_addr", fm_addr, 12'h00F);
            if (c == 9)   check("l15_col1_pat", pat, 8'hF1);
            if (c == 401) check("l15_line_done", line_done, 1);
        end
        start = 1'b1; prow = 4'd0;
        for (int c = 1; c <= 9; c++) begin
            step();
            start = 1'b0;
            if (c == 1) check("l0_col_restart", {rb_n, rb_addr}, 9'h000);
            if (c == 2) check("l0_font_addr", fm_addr, 12'h000);
            if (c == 9) check("l0_col1_pat", pat, 8'h01);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
